// File: rtl/cpu54_pkg.sv
// Shared definitions for the cpu54 exception path: sequencer state encoding,
// CP0 cause codes and status enable bit positions.
package cpu54_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TAKE     = 2'd1,
    S_REDIRECT = 2'd2,
    S_FLUSH    = 2'd3
  } exc_state_t;

  localparam logic [4:0] CAUSE_SYSCALL_C = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK_C   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ_C     = 5'b01101;
  localparam logic [4:0] CAUSE_INT_C     = 5'b00000;

  localparam int ST_IE  = 0;
  localparam int ST_SYS = 1;
  localparam int ST_BRK = 2;
  localparam int ST_TEQ = 3;
  localparam int ST_INT = 4;

endpackage

// File: rtl/exc_prio_sel.sv
// Enable gating and fixed-priority pick of one exception/ERET request:
// ERET > SYSCALL > BREAK > TEQ > pending interrupt.
module exc_prio_sel
  import cpu54_pkg::*;
#(
  parameter logic [4:0] CAUSE_SYSCALL = CAUSE_SYSCALL_C,
  parameter logic [4:0] CAUSE_BREAK   = CAUSE_BREAK_C,
  parameter logic [4:0] CAUSE_TEQ     = CAUSE_TEQ_C,
  parameter logic [4:0] CAUSE_INT     = CAUSE_INT_C
) (
  input  logic       instr_valid,
  input  logic       is_syscall,
  input  logic       is_break,
  input  logic       is_teq,
  input  logic       teq_eq,
  input  logic       is_eret,
  input  logic       irq_pend,
  input  logic [4:0] status_en,
  output logic       accept,
  output logic       is_eret_sel,
  output logic       is_int_sel,
  output logic [4:0] cause_sel
);

  logic syscall_en, break_en, teq_en, int_en;

  assign syscall_en = status_en[ST_IE] & status_en[ST_SYS];
  assign break_en   = status_en[ST_IE] & status_en[ST_BRK];
  assign teq_en     = status_en[ST_IE] & status_en[ST_TEQ] & teq_eq;
  assign int_en     = status_en[ST_IE] & status_en[ST_INT];

  always_comb begin
    accept      = 1'b0;
    is_eret_sel = 1'b0;
    is_int_sel  = 1'b0;
    cause_sel   = 5'd0;
    if (instr_valid && is_eret) begin
      accept      = 1'b1;
      is_eret_sel = 1'b1;
    end else if (instr_valid && is_syscall && syscall_en) begin
      accept    = 1'b1;
      cause_sel = CAUSE_SYSCALL;
    end else if (instr_valid && is_break && break_en) begin
      accept    = 1'b1;
      cause_sel = CAUSE_BREAK;
    end else if (instr_valid && is_teq && teq_en) begin
      accept    = 1'b1;
      cause_sel = CAUSE_TEQ;
    end else if (irq_pend && int_en) begin
      accept     = 1'b1;
      is_int_sel = 1'b1;
      cause_sel  = CAUSE_INT;
    end
  end

endmodule

// File: rtl/exc_seq_ctrl.sv
// Exception/ERET sequencer: accepts one request in IDLE, then drives a single
// CP0 update (TAKE), a PC redirect and a flush window while stalling the core.
module exc_seq_ctrl
  import cpu54_pkg::*;
#(
  parameter int         FLUSH_CYCLES  = 2,
  parameter logic [4:0] CAUSE_SYSCALL = CAUSE_SYSCALL_C,
  parameter logic [4:0] CAUSE_BREAK   = CAUSE_BREAK_C,
  parameter logic [4:0] CAUSE_TEQ     = CAUSE_TEQ_C,
  parameter logic [4:0] CAUSE_INT     = CAUSE_INT_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        teq_eq,
  input  logic        is_eret,
  input  logic        ext_irq,
  input  logic [31:0] pc,
  input  logic [31:0] status,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] epc,
  output logic        pc_redirect,
  output logic        stall,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  exc_state_t  state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        irq_pend, irq_pend_n;
  logic        lat_eret;
  logic [4:0]  lat_cause;
  logic [31:0] lat_epc;

  logic        sel_accept, sel_eret, sel_int;
  logic [4:0]  sel_cause;
  logic        take_go;
  logic        unused_status;

  assign unused_status = ^status[31:5];

  exc_prio_sel #(
    .CAUSE_SYSCALL (CAUSE_SYSCALL),
    .CAUSE_BREAK   (CAUSE_BREAK),
    .CAUSE_TEQ     (CAUSE_TEQ),
    .CAUSE_INT     (CAUSE_INT)
  ) u_prio (
    .instr_valid (instr_valid),
    .is_syscall  (is_syscall),
    .is_break    (is_break),
    .is_teq      (is_teq),
    .teq_eq      (teq_eq),
    .is_eret     (is_eret),
    .irq_pend    (irq_pend),
    .status_en   (status[4:0]),
    .accept      (sel_accept),
    .is_eret_sel (sel_eret),
    .is_int_sel  (sel_int),
    .cause_sel   (sel_cause)
  );

  // Handshake: a request is taken only in IDLE (take_go); stall acts as
  // not-ready to the core from the accepting cycle until the return to IDLE.
  assign take_go = (state == S_IDLE) && sel_accept;

  // Pending interrupt is only ever consumed by its own acceptance.
  assign irq_pend_n = (take_go && sel_int) ? 1'b0 : (irq_pend | ext_irq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      irq_pend  <= 1'b0;
      lat_eret  <= 1'b0;
      lat_cause <= 5'd0;
      lat_epc   <= 32'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      irq_pend <= irq_pend_n;
      if (take_go) begin
        lat_eret  <= sel_eret;
        lat_cause <= sel_cause;
        lat_epc   <= pc;
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    exception   = 1'b0;
    eret        = 1'b0;
    cause       = 5'd0;
    epc         = 32'd0;
    pc_redirect = 1'b0;
    stall       = 1'b0;
    busy        = 1'b0;
    case (state)
      S_IDLE: begin
        stall = take_go;
        if (take_go) state_n = S_TAKE;
      end
      S_TAKE: begin
        exception = 1'b1;
        eret      = lat_eret;
        cause     = lat_cause;
        epc       = lat_epc;
        stall     = 1'b1;
        busy      = 1'b1;
        state_n   = S_REDIRECT;
      end
      S_REDIRECT: begin
        eret        = lat_eret;
        cause       = lat_cause;
        epc         = lat_epc;
        pc_redirect = 1'b1;
        stall       = 1'b1;
        busy        = 1'b1;
        cnt_n       = 4'(FLUSH_CYCLES);
        state_n     = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: begin
        cause = lat_cause;
        epc   = lat_epc;
        stall = 1'b1;
        busy  = 1'b1;
        // Leave once the decremented count reaches zero: FLUSH lasts FLUSH_CYCLES cycles.
        if (cnt <= 4'd1) begin
          cnt_n   = 4'd0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Directed bench for exc_seq_ctrl: stimulus pushes one expected output vector
// per cycle; a negedge monitor pops and compares.
module tb_exc_seq_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        is_syscall = 1'b0, is_break = 1'b0, is_teq = 1'b0;
  logic        teq_eq = 1'b0, is_eret = 1'b0, ext_irq = 1'b0;
  logic [31:0] pc = 32'd0, status = 32'd0;
  logic        exception, eret, pc_redirect, stall, busy;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [1:0]  dbg_state;

  logic [41:0] exp_q[$];
  string       nm_q[$];
  int          total = 0;
  int          bad = 0;

  exc_seq_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_syscall(is_syscall),
    .is_break(is_break), .is_teq(is_teq), .teq_eq(teq_eq), .is_eret(is_eret),
    .ext_irq(ext_irq), .pc(pc), .status(status), .exception(exception),
    .eret(eret), .cause(cause), .epc(epc), .pc_redirect(pc_redirect),
    .stall(stall), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [41:0] pk(input logic ex, input logic er, input logic [4:0] c,
                                     input logic [31:0] e, input logic rd,
                                     input logic st, input logic bz);
    return {ex, er, c, e, rd, st, bz};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [41:0] act, e;
    string n;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = nm_q.pop_front();
      act = {exception, eret, cause, epc, pc_redirect, stall, busy};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: actual exc=%b eret=%b cause=%h epc=%h redir=%b stall=%b busy=%b required exc=%b eret=%b cause=%h epc=%h redir=%b stall=%b busy=%b",
                 n, act[41], act[40], act[39:35], act[34:3], act[2], act[1], act[0],
                 e[41], e[40], e[39:35], e[34:3], e[2], e[1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic step(input logic [41:0] e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_flags();
    instr_valid = 1'b0;
    is_syscall  = 1'b0;
    is_break    = 1'b0;
    is_teq      = 1'b0;
    teq_eq      = 1'b0;
    is_eret     = 1'b0;
  endtask

  task automatic idle_chk(input string nm);
    step(pk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0), nm);
  endtask

  // Caller sets request inputs; covers accept, TAKE, REDIRECT and every FLUSH cycle.
  task automatic run_seq(input logic er, input logic [4:0] c, input logic [31:0] p,
                         input logic irq_pulse, input string nm);
    step(pk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0), {nm, "_acc"});
    clr_flags();
    step(pk(1'b1, er, c, p, 1'b0, 1'b1, 1'b1), {nm, "_take"});
    step(pk(1'b0, er, c, p, 1'b1, 1'b1, 1'b1), {nm, "_redir"});
    for (int i = 0; i < FC; i++) begin
      if (irq_pulse && i == 0) ext_irq = 1'b1;
      step(pk(1'b0, 1'b0, c, p, 1'b0, 1'b1, 1'b1), {nm, "_flush"});
      ext_irq = 1'b0;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    idle_chk("reset");
    rst = 1'b0;
    idle_chk("post_reset");

    // SYSCALL entry
    status = 32'h0000_000F; pc = 32'h0040_0010;
    instr_valid = 1'b1; is_syscall = 1'b1;
    run_seq(1'b0, 5'b01000, 32'h0040_0010, 1'b0, "sys");
    idle_chk("sys_idle");

    // ERET with exceptions masked is still accepted
    status = 32'h0000_01E0; pc = 32'h8000_0180;
    instr_valid = 1'b1; is_eret = 1'b1;
    run_seq(1'b1, 5'd0, 32'h8000_0180, 1'b0, "eret");
    idle_chk("eret_idle");

    // TEQ not equal is a NOP, then TEQ equal traps
    status = 32'h0000_000F; pc = 32'h0040_0020;
    instr_valid = 1'b1; is_teq = 1'b1; teq_eq = 1'b0;
    idle_chk("teq_ne_nop");
    teq_eq = 1'b1;
    run_seq(1'b0, 5'b01101, 32'h0040_0020, 1'b0, "teq");
    idle_chk("teq_idle");

    // Masked BREAK ignored, then enabled BREAK taken
    status = 32'h0000_01E0; pc = 32'h0040_0030;
    instr_valid = 1'b1; is_break = 1'b1;
    idle_chk("brk_masked");
    idle_chk("brk_masked2");
    status = 32'h0000_000F;
    run_seq(1'b0, 5'b01001, 32'h0040_0030, 1'b0, "brk");

    // Priority: ERET beats SYSCALL; BREAK wins when SYSCALL is disabled
    status = 32'h0000_000F; pc = 32'h0040_0040;
    instr_valid = 1'b1; is_eret = 1'b1; is_syscall = 1'b1;
    run_seq(1'b1, 5'd0, 32'h0040_0040, 1'b0, "pri_eret");
    status = 32'h0000_0005; pc = 32'h0040_0044;
    instr_valid = 1'b1; is_syscall = 1'b1; is_break = 1'b1;
    run_seq(1'b0, 5'b01001, 32'h0040_0044, 1'b0, "pri_brk");
    idle_chk("pri_idle");

    // Interrupt pulse during FLUSH is held and taken in the first IDLE cycle
    status = 32'h0000_001F; pc = 32'h0040_0050;
    instr_valid = 1'b1; is_syscall = 1'b1;
    run_seq(1'b0, 5'b01000, 32'h0040_0050, 1'b1, "irq_sys");
    pc = 32'h0040_0054;
    run_seq(1'b0, 5'b00000, 32'h0040_0054, 1'b0, "irq");
    idle_chk("irq_cleared");

    // Masked interrupt stays pending until enabled
    status = 32'h0000_000F; pc = 32'h0040_0060;
    ext_irq = 1'b1;
    idle_chk("irq_mask_a");
    ext_irq = 1'b0;
    idle_chk("irq_mask_b");
    idle_chk("irq_mask_c");
    status = 32'h0000_001F;
    run_seq(1'b0, 5'b00000, 32'h0040_0060, 1'b0, "irq_late");
    idle_chk("irq_late_idle");

    // Async reset in REDIRECT, then a clean full sequence
    status = 32'h0000_000F; pc = 32'h0040_0070;
    instr_valid = 1'b1; is_syscall = 1'b1;
    step(pk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0), "rst_acc");
    clr_flags();
    step(pk(1'b1, 1'b0, 5'b01000, 32'h0040_0070, 1'b0, 1'b1, 1'b1), "rst_take");
    rst = 1'b1;
    idle_chk("rst_mid_redir");
    idle_chk("rst_held");
    rst = 1'b0;
    idle_chk("rst_released");
    pc = 32'h0040_0080;
    instr_valid = 1'b1; is_syscall = 1'b1;
    run_seq(1'b0, 5'b01000, 32'h0040_0080, 1'b0, "after_rst");
    idle_chk("final_idle");

    // final report
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: actual=%0d left required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_seq_ctrl.md
Name: exc_seq_ctrl

Overview:
- Exception/ERET sequencer for the 54-instruction MIPS core; the single driver of the CP0 `exception`, `eret`, `cause` and `pc` inputs.
- Takes decoded SYSCALL/BREAK/TEQ/ERET flags and a sticky external-interrupt line, and gates them against CP0 `status` enable bits.
- Runs a fixed multi-cycle entry/return sequence: one CP0 update cycle, a PC redirect, then pipeline flush. The core is stalled throughout.

Parameters:
- FLUSH_CYCLES, 2, stall cycles after redirect, before returning to IDLE; legal 0..15.
- CAUSE_SYSCALL, 5'b01000, cause code for SYSCALL.
- CAUSE_BREAK, 5'b01001, cause code for BREAK.
- CAUSE_TEQ, 5'b01101, cause code for TEQ trap.
- CAUSE_INT, 5'b00000, cause code for external interrupt.

Ports:
- clk  in  1  core clock; state updates on posedge (CP0 samples on negedge).
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  decode flags below are valid this cycle.
- is_syscall  in  1  decoded SYSCALL.
- is_break  in  1  decoded BREAK.
- is_teq  in  1  decoded TEQ.
- teq_eq  in  1  rs==rt for TEQ.
- is_eret  in  1  decoded ERET.
- ext_irq  in  1  external interrupt pulse/level.
- pc  in  32  address of the decoding instruction.
- status  in  32  CP0 status register.
- exception  out  1  to CP0 exception.
- eret  out  1  to CP0 eret.
- cause  out  5  to CP0 cause.
- epc  out  32  to CP0 pc input.
- pc_redirect  out  1  PC loads CP0 exc_addr this cycle.
- stall  out  1  freeze PC/regfile writes.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, TAKE, REDIRECT, FLUSH.
- Enable rules:
  - syscall_en = status[0] & status[1]
  - break_en = status[0] & status[2]
  - teq_en = status[0] & status[3] & teq_eq
  - int_en = status[0] & status[4]
  - ERET is always accepted.
- Request selection in IDLE, at most one per cycle, priority ERET > SYSCALL > BREAK > TEQ > pending interrupt. Decode flags count only when instr_valid=1.
- IDLE transitions:
  - On an accepted request, at the posedge: latch kind (eret flag), cause and epc=pc, then go to TAKE.
  - stall is combinationally 1 in the accepting cycle.
- A disabled exception instruction is treated as a NOP: no state change, no stall.
- TAKE lasts exactly 1 cycle:
  - exception=1, cause=latched code, epc=latched pc.
  - For ERET: eret=1 and cause=0.
  - CP0 performs exactly one update, on this cycle's negedge.
- REDIRECT lasts exactly 1 cycle:
  - pc_redirect=1, exception=0.
  - eret is held at 1 if the sequence is an ERET, so CP0 exc_addr selects EPC; otherwise eret=0 and exc_addr is the handler vector.
- FLUSH:
  - 4-bit counter loaded with FLUSH_CYCLES on entry; decrements each cycle.
  - Returns to IDLE when the counter reads 0.
  - If FLUSH_CYCLES=0, REDIRECT goes directly to IDLE.
- stall=1 in TAKE, REDIRECT and FLUSH. busy=1 in all non-IDLE states.
- Decode flags arriving while busy are ignored; the stalled instruction re-presents them after IDLE.
- ext_irq:
  - Sets a sticky irq_pend flag on any cycle, including busy cycles.
  - irq_pend is cleared when the interrupt is accepted.
  - irq_pend is never cleared by masking; it stays pending until enabled.
  - A simultaneous set and accept leaves it cleared.
- epc and cause are held stable from TAKE through FLUSH. In IDLE they drive 0.
- Reset, async at any point including mid-sequence:
  - state=IDLE, counter=0, irq_pend=0.
  - All outputs 0 (exception, eret, cause, epc, pc_redirect, stall, busy).
  - Next sequence starts cleanly with no partial CP0 update.
- Combinational outputs are derived from registered state only, except stall in the accepting IDLE cycle.

Decomposition:
- Shared package `cpu54_pkg`: state encoding (2-bit: IDLE=0, TAKE=1, REDIRECT=2, FLUSH=3), cause code constants, status bit indices (ST_IE=0, ST_SYS=1, ST_BRK=2, ST_TEQ=3, ST_INT=4).
- Optional sub-module `exc_prio_sel`: combinational enable gating plus priority encoder producing {accept, is_eret_sel, cause_sel}. The FSM, counter and irq latch stay in the top.

Test Plan:
- SYSCALL, status=32'h0000000F, pc=32'h00400010 -> TAKE cycle exception=1, cause=5'b01000, epc=32'h00400010; next cycle pc_redirect=1, eret=0; stall high for 2+FLUSH_CYCLES=4 cycles after accept; then IDLE.
- ERET with status=32'h000001E0 -> TAKE exception=1, eret=1; REDIRECT eret=1, pc_redirect=1, exception=0; CP0 status returns to 32'h0000000F.
- TEQ with teq_eq=0 -> no stall, busy=0. TEQ with teq_eq=1 and status[3]=1 -> cause=5'b01101.
- BREAK with status=32'h000001E0 (masked after prior entry) -> ignored, stall=0; the same BREAK with status=32'h0000000F -> cause=5'b01001.
- ext_irq 1-cycle pulse during a SYSCALL FLUSH with status=32'h0000001F -> irq_pend held; interrupt accepted in the first IDLE cycle, cause=5'b00000. With status[4]=0, pend stays 1 and no entry occurs.
- rst asserted mid-REDIRECT -> all outputs 0 immediately (async); after release, a new SYSCALL runs the full 4-cycle sequence.
